status_register: RTL and testbench
==================================

// Module: status_register
// PURPOSE
//   Holds the architectural NZCV flags for the ARM2 pipeline. Flags are written
//   from the EXE-stage ALU, from direct flag writes, and from exception
//   save/restore. The flags feed the ID-stage condition-check logic, which
//   decides whether each instruction executes.
//   Sits between the ALU flag outputs and the condition-check input. Provides a
//   registered flag output and a same-cycle bypass output for back-to-back
//   S-instruction dependence.
// PARAMETERS
//   RESET_STATUS  4'b0000  NZCV value loaded on rst
//   CNT_W         16       width of the flag-update event counter
//   BYPASS        1        1: status_fwd = next-state value; 0: status_fwd = status
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous, active-high reset
//   s_en          in   1      EXE instruction is valid, passed its condition, and has the S bit set
//   alu_status    in   4      {N,Z,C,V} produced by the ALU this cycle
//   wr_en         in   1      direct flag write (MSR-flags form)
//   wr_data       in   4      {N,Z,C,V} for the direct write
//   save          in   1      exception entry: copy status to saved_status
//   restore       in   1      exception return: status <= saved_status
//   freeze        in   1      pipeline stall: hold all state
//   flush         in   1      EXE is being squashed: suppress s_en and wr_en
//   status        out  4      registered {N,Z,C,V}, bit3=N ... bit0=V
//   status_fwd    out  4      bypass value for condition check (see BYPASS)
//   saved_status  out  4      registered saved copy
//   changed       out  1      registered one-cycle pulse: status value changed last cycle
//   update_cnt    out  CNT_W  count of accepted flag writes (s_en or wr_en)
// BEHAVIOUR
//   Reset (rst=1 at posedge): status=RESET_STATUS, saved_status=RESET_STATUS,
//     changed=0, update_cnt=0. rst overrides every other input.
//   freeze=1: no register changes, including changed and update_cnt.
//     status_fwd=status regardless of BYPASS.
//   Effective strobes when not frozen:
//     s_eff=s_en&~flush; w_eff=wr_en&~flush. save and restore are not gated by flush.
//   Next status priority (highest first): restore -> saved_status;
//     w_eff -> wr_data; s_eff -> alu_status; else hold.
//   Partial flag update is not supported. All four bits are written together.
//   save: saved_status <= current registered status, i.e. the pre-update value.
//     save & restore in the same cycle swaps the values: status <= old saved,
//     saved <= old status.
//   changed <= (next status != status) on every non-frozen cycle. It is 0 after
//     a write of an identical value.
//   update_cnt increments by 1 when (w_eff|s_eff) and ~restore. Writes that lose
//     to restore are not counted. The counter wraps modulo 2^CNT_W without
//     saturating.
//   status_fwd (BYPASS=1, not frozen): combinational next status value. This is
//     zero-latency forwarding; the registered status follows with 1-cycle latency.
//   No internal FSM beyond the register set. No X propagation: inputs are used
//     only when their strobe is asserted.
// TESTING
//   1 rst -> status=0000, saved=0000, cnt=0, changed=0. Then s_en=1,
//     alu_status=1010 -> next cycle status=1010, cnt=1, changed=1;
//     status_fwd=1010 in the same cycle as s_en.
//   2 Priority: s_en=1 alu=0001, wr_en=1 wr_data=0100 -> status=0100, cnt=1.
//     Add restore=1 with saved=1111 -> status=1111, cnt unchanged.
//   3 flush=1 with s_en=1 alu=0110 -> status holds, cnt holds, changed=0.
//     flush=1 with restore=1 -> restore still takes effect.
//   4 Hold and restore: status=1100, save=1 -> saved=1100. Then s_en=1 alu=0011
//     -> status=0011. Then restore=1 -> status=1100.
//     save&restore together with status=0011, saved=1100 -> swap.
//   5 freeze=1 with s_en, wr_en, save and restore all asserted for 3 cycles
//     -> all outputs constant, status_fwd=status. rst asserted during freeze
//     -> reset values.
//   6 CNT_W=4: 16 consecutive s_en writes -> update_cnt wraps to 0.
//     Writing the same value twice -> changed=0 on the second write.

Source files
------------

// File: rtl/status_register_if.sv
// Flag-register bus: ALU/direct/exception strobes in, registered and forwarded NZCV out.
interface status_register_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned FLAG_W = 4;

    logic              s_en;
    logic [FLAG_W-1:0] alu_status;
    logic              wr_en;
    logic [FLAG_W-1:0] wr_data;
    logic              save;
    logic              restore;
    logic              freeze;
    logic              flush;
    logic [FLAG_W-1:0] status;
    logic [FLAG_W-1:0] status_fwd;
    logic [FLAG_W-1:0] saved_status;
    logic              changed;
    logic [CNT_W-1:0]  update_cnt;

    modport master (
        output s_en, alu_status, wr_en, wr_data, save, restore, freeze, flush,
        input  status, status_fwd, saved_status, changed, update_cnt
    );

    modport slave (
        input  s_en, alu_status, wr_en, wr_data, save, restore, freeze, flush,
        output status, status_fwd, saved_status, changed, update_cnt
    );
endinterface

// File: rtl/status_register.sv
// Architectural NZCV flag register with exception save/restore, change pulse,
// update counter and a zero-latency bypass for the ID-stage condition check.
module status_register #(
    parameter logic [3:0]  RESET_STATUS = 4'b0000,
    parameter int unsigned CNT_W        = 16,
    parameter bit          BYPASS       = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    status_register_if.slave   bus
);
    localparam int unsigned FLAG_W = 4;

    logic [FLAG_W-1:0] status_q;
    logic [FLAG_W-1:0] saved_q;
    logic              changed_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              s_eff;
    logic              w_eff;
    logic              cnt_inc;
    logic [FLAG_W-1:0] status_nxt;

    // Next-state selection: restore beats direct write beats ALU write.
    always_comb begin
        s_eff      = bus.s_en & ~bus.flush;
        w_eff      = bus.wr_en & ~bus.flush;
        cnt_inc    = (s_eff | w_eff) & ~bus.restore;
        status_nxt = status_q;
        if (bus.restore) begin
            status_nxt = saved_q;
        end else if (w_eff) begin
            status_nxt = bus.wr_data;
        end else if (s_eff) begin
            status_nxt = bus.alu_status;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= RESET_STATUS;
            saved_q   <= RESET_STATUS;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else if (!bus.freeze) begin
            status_q  <= status_nxt;
            changed_q <= (status_nxt != status_q);
            // Save captures the pre-update value, so save+restore swaps.
            if (bus.save) begin
                saved_q <= status_q;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.status       = status_q;
    assign bus.saved_status = saved_q;
    assign bus.changed      = changed_q;
    assign bus.update_cnt   = cnt_q;
    assign bus.status_fwd   = (BYPASS && !bus.freeze) ? status_nxt : status_q;
endmodule

// File: tb/tb_status_register.sv
// Directed scoreboard bench for status_register (4-bit counter to exercise wrap).
module tb_status_register;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [3:0]       st;
        logic [3:0]       sv;
        logic             ch;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    status_register_if #(.CNT_W(CNT_W)) bus ();

    status_register #(
        .RESET_STATUS(4'b0000),
        .CNT_W       (CNT_W),
        .BYPASS      (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t       sb[$];
    int         n_vec;
    int         n_err;
    logic [3:0] m_status;
    logic [3:0] m_saved;
    logic       m_changed;
    logic [CNT_W-1:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_status"},  16'(bus.status),       16'(e.st));
            check({tag, "_saved"},   16'(bus.saved_status), 16'(e.sv));
            check({tag, "_changed"}, 16'(bus.changed),      16'(e.ch));
            check({tag, "_cnt"},     16'(bus.update_cnt),   16'(e.cnt));
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.st  = m_status;
        e.sv  = m_saved;
        e.ch  = m_changed;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic do_reset(input string tag, input logic fz);
        @(negedge clk);
        rst = 1'b1;
        bus.freeze = fz;
        bus.s_en = fz; bus.wr_en = fz; bus.save = fz; bus.restore = fz;
        bus.alu_status = 4'b1111; bus.wr_data = 4'b1111;
        m_status = 4'b0000; m_saved = 4'b0000; m_changed = 1'b0; m_cnt = '0;
        push_model();
        @(posedge clk);
        #1;
        pop_check(tag);
        rst = 1'b0;
        bus.freeze = 1'b0;
        bus.s_en = 1'b0; bus.wr_en = 1'b0; bus.save = 1'b0; bus.restore = 1'b0;
    endtask

    // One clock of stimulus: check bypass before the edge, registers after it.
    task automatic step(input string tag, input logic s, input logic [3:0] alu,
                        input logic w, input logic [3:0] wd, input logic sv,
                        input logic rs, input logic fz, input logic fl);
        logic [3:0] nxt;
        @(negedge clk);
        bus.s_en = s; bus.alu_status = alu; bus.wr_en = w; bus.wr_data = wd;
        bus.save = sv; bus.restore = rs; bus.freeze = fz; bus.flush = fl;
        if (rs)            nxt = m_saved;
        else if (w && !fl) nxt = wd;
        else if (s && !fl) nxt = alu;
        else               nxt = m_status;
        #1;
        check({tag, "_fwd"}, 16'(bus.status_fwd), 16'(fz ? m_status : nxt));
        if (!fz) begin
            m_changed = (nxt != m_status);
            if (sv) m_saved = m_status;
            if ((s || w) && !fl && !rs) m_cnt = m_cnt + 1'b1;
            m_status = nxt;
        end
        push_model();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0;
        bus.s_en = 1'b0; bus.alu_status = 4'b0000; bus.wr_en = 1'b0; bus.wr_data = 4'b0000;
        bus.save = 1'b0; bus.restore = 1'b0; bus.freeze = 1'b0; bus.flush = 1'b0;

        // Reset and first ALU write with same-cycle bypass
        do_reset("rst0", 1'b0);
        step("alu1010", 1, 4'b1010, 0, 4'b0000, 0, 0, 0, 0);

        // Priority: direct write over ALU, restore over both
        step("prio_w",   1, 4'b0001, 1, 4'b0100, 0, 0, 0, 0);
        step("set1111",  0, 4'b0000, 1, 4'b1111, 0, 0, 0, 0);
        step("save1111", 0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0);
        step("set0000",  0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        step("prio_rs",  1, 4'b0001, 1, 4'b0100, 0, 1, 0, 0);

        // Flush suppresses writes but not restore
        step("flush_s",  1, 4'b0110, 0, 4'b0000, 0, 0, 0, 1);
        step("set0101",  0, 4'b0000, 1, 4'b0101, 0, 0, 0, 0);
        step("flush_rs", 1, 4'b0110, 1, 4'b0011, 0, 1, 0, 1);

        // Save/restore round trip and swap
        step("set1100",  0, 4'b0000, 1, 4'b1100, 0, 0, 0, 0);
        step("save1100", 0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0);
        step("alu0011",  1, 4'b0011, 0, 4'b0000, 0, 0, 0, 0);
        step("rest1100", 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0);
        step("alu0011b", 1, 4'b0011, 0, 4'b0000, 0, 0, 0, 0);
        step("swap",     0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);

        // Freeze holds everything, rst still wins
        for (int i = 0; i < 3; i++)
            step($sformatf("freeze%0d", i), 1, 4'b0110, 1, 4'b1001, 1, 1, 1, 0);
        do_reset("rst_frz", 1'b1);

        // Counter wrap after 16 accepted writes
        for (int i = 0; i < 16; i++)
            step($sformatf("wrap%0d", i), 1, 4'($urandom_range(0, 15)), 0, 4'b0000, 0, 0, 0, 0);
        check("wrap_cnt_zero", 16'(bus.update_cnt), 16'd0);

        // Identical value twice: changed drops on the second
        step("same_a", 1, 4'b1001, 0, 4'b0000, 0, 0, 0, 0);
        step("same_b", 1, 4'b1001, 0, 4'b0000, 0, 0, 0, 0);
        check("same_changed", 16'(bus.changed), 16'd0);

        // Mixed random traffic
        for (int i = 0; i < 40; i++)
            step($sformatf("rnd%0d", i), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
